program_loader: RTL and testbench



---
 rtl/program_loader_if.sv | 10 +
 rtl/program_loader.sv | 131 +++++++++++++
 tb/tb_program_loader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream handshake into the program loader: one byte moves on each
// rising edge where in_valid and in_ready are both high.
interface program_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/program_loader.sv
// Boot loader: parses a framed image (A5, LE32 length, payload, checksum),
// writes it byte-wise into core memory and releases the core only after verification.
//
// state | meaning
// IDLE  | hunting for the 0xA5 magic byte, core held in reset
// LEN   | shifting in the 4-byte little-endian length
// DATA  | writing payload bytes to addresses 0..N-1
// CSUM  | comparing the received checksum byte
// DONE  | image verified, core released (terminal until reset)
// ERR   | load aborted, core held in reset (terminal until reset)
module program_loader #(
  parameter int WIDTH          = 32,
  parameter int MEM_DEPTH      = 4096,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clock,
  input  logic             reset,
  program_loader_if.slave  stream,
  output logic             mem_en,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_data,
  output logic             cpu_reset,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] bytes_loaded
);

  localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] MAX_LEN = MEM_DEPTH;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t          state;
  logic [31:0]     len_val;
  logic [1:0]      len_cnt;
  logic [31:0]     idx;
  logic [7:0]      csum;
  logic [TW-1:0]   timer;

  logic            active;
  logic            xfer;
  logic [31:0]     len_next;
  logic [31:0]     idx_next;

  assign active          = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign stream.in_ready = !reset && (active || state == S_IDLE);
  assign xfer            = stream.in_valid && stream.in_ready;
  assign len_next        = {stream.in_data, len_val[31:8]};
  assign idx_next        = idx + 32'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      len_val      <= '0;
      len_cnt      <= '0;
      idx          <= '0;
      csum         <= '0;
      timer        <= TIMER_LOAD;
      mem_en       <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      bytes_loaded <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      if (active && !xfer) begin
        // Down-counting idle timer; terminal count aborts the frame.
        if (timer <= TW'(1)) begin
          state <= S_ERR;
          error <= 1'b1;
        end else begin
          timer <= timer - TW'(1);
        end
      end else if (xfer) begin
        timer <= TIMER_LOAD;
        case (state)
          S_IDLE: begin
            if (stream.in_data == 8'hA5) begin
              state        <= S_LEN;
              len_val      <= '0;
              len_cnt      <= '0;
              idx          <= '0;
              csum         <= '0;
              bytes_loaded <= '0;
            end
          end
          S_LEN: begin
            len_val <= len_next;
            len_cnt <= len_cnt + 2'd1;
            if (len_cnt == 2'd3) begin
              if (len_next > MAX_LEN) begin
                state <= S_ERR;
                error <= 1'b1;
              end else if (len_next == 32'd0) begin
                state <= S_CSUM;
              end else begin
                state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            mem_en       <= 1'b1;
            mem_addr     <= WIDTH'(idx);
            mem_data     <= {{(WIDTH-8){1'b0}}, stream.in_data};
            csum         <= csum + stream.in_data;
            idx          <= idx_next;
            bytes_loaded <= WIDTH'(idx_next);
            if (idx_next == len_val) state <= S_CSUM;
          end
          S_CSUM: begin
            if (stream.in_data == csum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a frame-level reference model that
// is compared against the DUT outputs on every cycle.
module tb_program_loader;
  localparam int WIDTH = 32;
  localparam int MEM_DEPTH = 4096;
  localparam int TMO = 8;

  localparam int P_IDLE = 0, P_LEN = 1, P_DATA = 2, P_CSUM = 3, P_DONE = 4, P_ERR = 5;

  logic clock = 1'b0;
  logic reset;
  logic mem_en, cpu_reset, done, error;
  logic [WIDTH-1:0] mem_addr, mem_data, bytes_loaded;

  program_loader_if bus ();

  program_loader #(.WIDTH(WIDTH), .MEM_DEPTH(MEM_DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .stream(bus.slave),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_reset(cpu_reset), .done(done), .error(error), .bytes_loaded(bytes_loaded)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame parser expressed with plain counters.
  int          phase = P_IDLE;
  int unsigned n_len, len_seen, n_done, gap;
  logic [7:0]  sum;
  logic        e_mem_en = 0;
  logic [31:0] e_addr = 0, e_data = 0, e_loaded = 0;
  logic        e_done = 0, e_error = 0, e_cpu_reset = 1;

  function automatic logic model_ready(input int p, input logic rst);
    return !rst && (p == P_IDLE || p == P_LEN || p == P_DATA || p == P_CSUM);
  endfunction

  always @(posedge clock) begin
    logic x;
    logic [7:0] b;
    x = bus.in_valid && model_ready(phase, reset);
    b = bus.in_data;
    e_mem_en = 0;
    if (reset) begin
      phase = P_IDLE; e_addr = 0; e_data = 0; e_loaded = 0;
    end else if (phase == P_LEN || phase == P_DATA || phase == P_CSUM) begin
      if (!x) begin
        gap++;
        if (gap == TMO) phase = P_ERR;
      end else begin
        gap = 0;
        if (phase == P_LEN) begin
          n_len = n_len + (32'(b) << (8 * len_seen));
          len_seen++;
          if (len_seen == 4)
            phase = (n_len > MEM_DEPTH) ? P_ERR : (n_len == 0) ? P_CSUM : P_DATA;
        end else if (phase == P_DATA) begin
          e_mem_en = 1; e_addr = n_done; e_data = 32'(b);
          sum = sum + b; n_done++; e_loaded = n_done;
          if (n_done == n_len) phase = P_CSUM;
        end else begin
          phase = (b == sum) ? P_DONE : P_ERR;
        end
      end
    end else if (phase == P_IDLE && x && b == 8'hA5) begin
      phase = P_LEN; n_len = 0; len_seen = 0; n_done = 0; sum = 0; gap = 0; e_loaded = 0;
    end
    e_done = (phase == P_DONE);
    e_error = (phase == P_ERR);
    e_cpu_reset = (phase != P_DONE);
  end

  // Capture of what the DUT actually wrote, for literal image checks.
  logic [7:0] dut_mem [0:15];
  int pulses = 0;
  always @(posedge clock) begin
    if (mem_en === 1'b1) begin
      pulses++;
      if (mem_addr < 16) dut_mem[mem_addr[3:0]] = mem_data[7:0];
    end
  end

  always @(negedge clock) begin
    chk("in_ready", bus.in_ready, model_ready(phase, reset));
    chk("mem_en", mem_en, e_mem_en);
    if (e_mem_en) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_data", mem_data, e_data);
    end
    chk("cpu_reset", cpu_reset, e_cpu_reset);
    chk("done", done, e_done);
    chk("error", error, e_error);
    chk("bytes_loaded", bytes_loaded, e_loaded);
  end

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic send_list(input logic [7:0] q[$], input bit gaps);
    foreach (q[i]) begin
      send(q[i]);
      if (gaps) idle(1);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_data", mem_data, 32'd0);
    chk("rst_loaded", bytes_loaded, 32'd0);
    chk("rst_cpu_reset", cpu_reset, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_ready", bus.in_ready, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) dut_mem[i] = 8'h00;
  endtask

  initial begin
    int p0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    idle(2);
    do_reset();

    // Back-to-back 4-byte image.
    p0 = pulses;
    send_list('{8'hA5, 8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00}, 0);
    send(8'h13);
    idle(1);
    chk("t1_done_next", done, 1'b1);
    chk("t1_cpu_run", cpu_reset, 1'b0);
    idle(3);
    chk("t1_pulses", pulses - p0, 4);
    chk("t1_mem0", dut_mem[0], 8'h13);
    chk("t1_mem1", dut_mem[1], 8'h00);
    chk("t1_loaded", bytes_loaded, 32'd4);
    chk("t1_model_loaded", e_loaded, 32'd4);
    chk("t1_hold_ready", bus.in_ready, 1'b0);

    // Garbage ahead of the magic byte.
    do_reset();
    p0 = pulses;
    send_list('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h00, 8'h00, 8'h00}, 0);
    idle(1);
    chk("t2_no_write_yet", pulses - p0, 0);
    send_list('{8'h11, 8'h22, 8'h33}, 0);
    idle(3);
    chk("t2_done", done, 1'b1);
    chk("t2_mem0", dut_mem[0], 8'h11);
    chk("t2_mem1", dut_mem[1], 8'h22);
    chk("t2_pulses", pulses - p0, 2);

    // Length 4097 is one past the memory size.
    do_reset();
    p0 = pulses;
    send_list('{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00}, 0);
    idle(1);
    chk("t3_error", error, 1'b1);
    idle(4);
    chk("t3_pulses", pulses - p0, 0);
    chk("t3_cpu_reset", cpu_reset, 1'b1);

    // Length exactly MEM_DEPTH is accepted.
    do_reset();
    send_list('{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h01}, 0);
    idle(1);
    chk("t3b_no_error", error, 1'b0);

    // Bad checksum after four writes.
    do_reset();
    p0 = pulses;
    send_list('{8'hA5, 8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14}, 0);
    idle(3);
    chk("t4_pulses", pulses - p0, 4);
    chk("t4_error", error, 1'b1);
    chk("t4_done", done, 1'b0);
    chk("t4_cpu_reset", cpu_reset, 1'b1);

    // Zero-length image needs checksum 0x00.
    do_reset();
    send_list('{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0);
    idle(2);
    chk("t0_done", done, 1'b1);
    chk("t0_loaded", bytes_loaded, 32'd0);

    // Alternating valid during payload.
    do_reset();
    p0 = pulses;
    send_list('{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00}, 0);
    send_list('{8'h01, 8'h02, 8'h03}, 1);
    send(8'h06);
    idle(3);
    chk("t5_done", done, 1'b1);
    chk("t5_pulses", pulses - p0, 3);
    chk("t5_mem2", dut_mem[2], 8'h03);

    // Nine-cycle gap inside a frame trips the timeout.
    do_reset();
    send_list('{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h05}, 0);
    idle(9);
    chk("t5b_error", error, 1'b1);
    chk("t5b_loaded", bytes_loaded, 32'd1);

    // Reset mid-payload, then a clean frame.
    do_reset();
    send_list('{8'hA5, 8'h04, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB}, 0);
    do_reset();
    send_list('{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03}, 0);
    idle(3);
    chk("t6_done", done, 1'b1);
    chk("t6_loaded", bytes_loaded, 32'd2);
    chk("t6_mem1", dut_mem[1], 8'h02);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
